// File: rtl/rsa_residue_gen.sv
// ---------------------------------------------------------------------------
// rsa_residue_gen
//
// Computes the Montgomery conversion constant R^2 mod M, with R = 2^KEY_WIDTH.
// Starting from r = 1 the block performs 2*KEY_WIDTH modular doublings, one
// per clock (shift left, subtract M once if the result reaches M). This leaves
// r = 2^(2*KEY_WIDTH) mod M. The result feeds the residue register of the
// RSA MMIO engine.
//
// Ports
//   pclk           clock, rising edge
//   nreset         synchronous, active-low reset
//   start          request a computation (sampled only while idle)
//   abort          cancel an in-flight computation; also blocks start in idle
//   modulus        M, latched when start is accepted
//   busy           high while iterating (exactly 2*KEY_WIDTH cycles)
//   done           one-cycle completion pulse (normal or error)
//   residue_valid  sticky: residue holds R^2 mod M for the latched M
//   residue        result
//   error          sticky: the latched M was rejected (even, 0 or 1)
// ---------------------------------------------------------------------------
module rsa_residue_gen #(
    parameter int KEY_WIDTH = 64,
    parameter int CNT_W     = $clog2(2*KEY_WIDTH)+1
) (
    input  logic                 pclk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [KEY_WIDTH-1:0] modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 residue_valid,
    output logic [KEY_WIDTH-1:0] residue,
    output logic                 error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2*KEY_WIDTH-1);

    state_t               state_q,   state_d;
    logic [KEY_WIDTH-1:0] m_q,       m_d;
    logic [KEY_WIDTH-1:0] r_q,       r_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 done_q,    done_d;
    logic                 valid_q,   valid_d;
    logic                 err_q,     err_d;
    logic [KEY_WIDTH-1:0] residue_q, residue_d;

    // One modular doubling step. Because r < M, 2r < 2M, so one conditional
    // subtract is enough. The subtract can be done in KEY_WIDTH bits: when it
    // is selected the true difference is below M and therefore fits.
    logic [KEY_WIDTH:0]   dbl;
    logic                 dbl_ge_m;
    logic [KEY_WIDTH-1:0] dbl_minus_m;
    logic [KEY_WIDTH-1:0] r_step;

    assign dbl         = {r_q, 1'b0};
    assign dbl_ge_m    = (dbl >= {1'b0, m_q});
    assign dbl_minus_m = dbl[KEY_WIDTH-1:0] - m_q;
    assign r_step      = dbl_ge_m ? dbl_minus_m : dbl[KEY_WIDTH-1:0];

    // A modulus is usable only if it is odd and at least 3.
    logic mod_ok;
    assign mod_ok = modulus[0] && (modulus != KEY_WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        err_d     = err_q;
        residue_d = residue_q;

        case (state_q)
            IDLE: begin
                // abort has priority over start while idle.
                if (start && !abort) begin
                    m_d       = modulus;
                    valid_d   = 1'b0;
                    err_d     = 1'b0;
                    residue_d = '0;
                    if (mod_ok) begin
                        r_d     = KEY_WIDTH'(1);
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        // Rejected modulus: report in the very next cycle.
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    valid_d   = 1'b0;
                    err_d     = 1'b0;
                    residue_d = '0;
                    state_d   = IDLE;
                end else begin
                    r_d   = r_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        // Outputs are registered here so that done, residue
                        // and residue_valid all appear together in the FIN cycle.
                        residue_d = r_step;
                        valid_d   = 1'b1;
                        err_d     = 1'b0;
                        done_d    = 1'b1;
                        state_d   = FIN;
                    end
                end
            end

            FIN: begin
                // The done pulse is already out; an abort here withdraws the
                // sticky status so the result is not used.
                if (abort) begin
                    valid_d   = 1'b0;
                    err_d     = 1'b0;
                    residue_d = '0;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            residue_q <= residue_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = done_q;
    assign residue_valid = valid_q;
    assign residue       = residue_q;
    assign error         = err_q;

endmodule

// File: tb/tb_rsa_residue_gen.sv
// ---------------------------------------------------------------------------
// tb_rsa_residue_gen
//
// Drives a 64-bit and an 8-bit instance of rsa_residue_gen. Expected results
// are queued when a start is driven and compared when done pulses. Reference
// residues come from a direct wide modulo 2^(2W) % M.
// ---------------------------------------------------------------------------
module tb_rsa_residue_gen;

    logic        pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        nreset;

    logic        start64, abort64;
    logic [63:0] mod64;
    logic        busy64, done64, valid64, error64;
    logic [63:0] residue64;

    logic        start8, abort8;
    logic [7:0]  mod8;
    logic        busy8, done8, valid8, error8;
    logic [7:0]  residue8;

    rsa_residue_gen #(.KEY_WIDTH(64)) dut64 (
        .pclk          (pclk),
        .nreset        (nreset),
        .start         (start64),
        .abort         (abort64),
        .modulus       (mod64),
        .busy          (busy64),
        .done          (done64),
        .residue_valid (valid64),
        .residue       (residue64),
        .error         (error64)
    );

    rsa_residue_gen #(.KEY_WIDTH(8)) dut8 (
        .pclk          (pclk),
        .nreset        (nreset),
        .start         (start8),
        .abort         (abort8),
        .modulus       (mod8),
        .busy          (busy8),
        .done          (done8),
        .residue_valid (valid8),
        .residue       (residue8),
        .error         (error8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        bit          err;
    } exp_t;

    typedef struct {
        logic [63:0] m;
        logic [63:0] res;
        bit          err;
    } vec_t;

    exp_t q64[$];
    exp_t q8[$];
    int   done64_cnt = 0;
    int   done8_cnt  = 0;

    localparam logic [63:0] PRIME = 64'hFFFF_FFFF_FFFF_FFC5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [63:0] m, input int w);
        logic [128:0] p;
        logic [128:0] r;
        p = 129'd1 << (2*w);
        r = p % {65'd0, m};
        return r[63:0];
    endfunction

    // Scoreboard monitors: sample mid-cycle, pop one expectation per done.
    always @(negedge pclk) begin : mon64
        exp_t e;
        if (nreset && done64 === 1'b1) begin
            done64_cnt++;
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done64_unexpected: got done with residue 0x%h, expected no done", residue64);
            end else begin
                e = q64.pop_front();
                chk("residue64", residue64, e.res);
                chk("valid64", {63'd0, valid64}, {63'd0, ~e.err});
                chk("error64", {63'd0, error64}, {63'd0, e.err});
                chk("busy_at_done64", {63'd0, busy64}, 64'd0);
                $display("txn w=64 residue=0x%h valid=%0b error=%0b", residue64, valid64, error64);
            end
        end
    end

    always @(negedge pclk) begin : mon8
        exp_t e;
        if (nreset && done8 === 1'b1) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done with residue 0x%h, expected no done", residue8);
            end else begin
                e = q8.pop_front();
                chk("residue8", {56'd0, residue8}, e.res);
                chk("valid8", {63'd0, valid8}, {63'd0, ~e.err});
                chk("error8", {63'd0, error8}, {63'd0, e.err});
                chk("busy_at_done8", {63'd0, busy8}, 64'd0);
                $display("txn w=8 residue=0x%h valid=%0b error=%0b", residue8, valid8, error8);
            end
        end
    end

    // One full transaction: pulse start, push expectation, count busy cycles
    // and latency (cycle t0+1 counts as 1) until done appears.
    task automatic run(input bit w8, input logic [63:0] m, input logic [63:0] er,
                       input bit ee, input bit disturb, input string name);
        int   lat;
        int   bc;
        int   w;
        exp_t e;
        w     = w8 ? 8 : 64;
        e.res = er;
        e.err = ee;
        @(posedge pclk); #1;
        if (w8) begin
            start8 = 1'b1;
            mod8   = m[7:0];
            q8.push_back(e);
        end else begin
            start64 = 1'b1;
            mod64   = m;
            q64.push_back(e);
        end
        @(posedge pclk); #1;
        start8  = 1'b0;
        start64 = 1'b0;
        lat = 1;
        bc  = 0;
        while (!(w8 ? done8 : done64) && lat < 400) begin
            if (w8 ? busy8 : busy64) bc++;
            if (disturb && lat == 20) begin
                start64 = 1'b1;
                mod64   = {$urandom, $urandom};
            end
            if (disturb && lat == 21) start64 = 1'b0;
            @(posedge pclk); #1;
            lat++;
        end
        if (lat >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, lat);
        end
        chk({name, "_latency"}, 64'(lat), ee ? 64'd1 : 64'(2*w+1));
        chk({name, "_busy_cycles"}, 64'(bc), ee ? 64'd0 : 64'(2*w));
    endtask

    initial begin
        vec_t        tbl[7];
        logic [63:0] m;
        int          dc;

        tbl[0] = '{PRIME,                   64'h0000_0000_0000_0D99, 1'b0};
        tbl[1] = '{64'd3,                   64'd1,                   1'b0};
        tbl[2] = '{64'h8000_0000_0000_0001, 64'd4,                   1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   1'b0};
        tbl[4] = '{64'd10,                  64'd0,                   1'b1};
        tbl[5] = '{64'd0,                   64'd0,                   1'b1};
        tbl[6] = '{64'd1,                   64'd0,                   1'b1};

        nreset  = 1'b0;
        start64 = 1'b0; abort64 = 1'b0; mod64 = '0;
        start8  = 1'b0; abort8  = 1'b0; mod8  = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_busy",    {63'd0, busy64},  64'd0);
        chk("rst_done",    {63'd0, done64},  64'd0);
        chk("rst_valid",   {63'd0, valid64}, 64'd0);
        chk("rst_error",   {63'd0, error64}, 64'd0);
        chk("rst_residue", residue64,        64'd0);
        nreset = 1'b1;

        // Directed table: prime, edge moduli, rejected moduli.
        for (int i = 0; i < 7; i++) begin
            run(1'b0, tbl[i].m, tbl[i].res, tbl[i].err, 1'b0, $sformatf("tbl%0d", i));
        end

        // start pulses and modulus changes mid-run must not disturb anything.
        run(1'b0, PRIME, 64'h0D99, 1'b0, 1'b1, "disturb");

        // Result holds after done.
        repeat (5) @(posedge pclk);
        #1;
        chk("hold_residue", residue64,        64'h0D99);
        chk("hold_valid",   {63'd0, valid64}, 64'd1);

        // abort in idle overrides start: nothing changes.
        abort64 = 1'b1; start64 = 1'b1; mod64 = 64'd3;
        @(posedge pclk); #1;
        abort64 = 1'b0; start64 = 1'b0;
        @(posedge pclk); #1;
        chk("idle_abort_busy",    {63'd0, busy64},  64'd0);
        chk("idle_abort_residue", residue64,        64'h0D99);
        chk("idle_abort_valid",   {63'd0, valid64}, 64'd1);

        // Abort at iteration 50.
        dc = done64_cnt;
        start64 = 1'b1; mod64 = PRIME;
        @(posedge pclk); #1;
        start64 = 1'b0;
        repeat (49) begin @(posedge pclk); #1; end
        chk("abort_pre_busy", {63'd0, busy64}, 64'd1);
        abort64 = 1'b1;
        @(posedge pclk); #1;
        abort64 = 1'b0;
        chk("abort_busy",  {63'd0, busy64},  64'd0);
        chk("abort_done",  {63'd0, done64},  64'd0);
        chk("abort_valid", {63'd0, valid64}, 64'd0);
        chk("abort_error", {63'd0, error64}, 64'd0);
        repeat (150) @(posedge pclk);
        #1;
        chk("abort_no_done", 64'(done64_cnt), 64'(dc));
        run(1'b0, 64'd3, 64'd1, 1'b0, 1'b0, "after_abort");

        // Reset at iteration 100.
        @(posedge pclk); #1;
        start64 = 1'b1; mod64 = PRIME;
        @(posedge pclk); #1;
        start64 = 1'b0;
        repeat (99) begin @(posedge pclk); #1; end
        nreset = 1'b0;
        @(posedge pclk); #1;
        nreset = 1'b1;
        chk("midrst_busy",    {63'd0, busy64},  64'd0);
        chk("midrst_done",    {63'd0, done64},  64'd0);
        chk("midrst_valid",   {63'd0, valid64}, 64'd0);
        chk("midrst_error",   {63'd0, error64}, 64'd0);
        chk("midrst_residue", residue64,        64'd0);
        run(1'b0, PRIME, 64'h0D99, 1'b0, 1'b0, "after_reset");

        // Randomised odd moduli, back-to-back starts.
        for (int i = 0; i < 200; i++) begin
            m = {$urandom, $urandom} | 64'd1;
            if (m == 64'd1) m = 64'd3;
            run(1'b0, m, ref_res(m, 64), 1'b0, 1'b0, "rand64");
        end
        for (int i = 0; i < 200; i++) begin
            m = 64'($urandom_range(3, 255)) | 64'd1;
            run(1'b1, m, ref_res(m, 8), 1'b0, 1'b0, "rand8");
        end
        run(1'b1, 64'd4, 64'd0, 1'b1, 1'b0, "even8");

        repeat (3) @(posedge pclk);
        #1;
        chk("sb_empty64", 64'(q64.size()), 64'd0);
        chk("sb_empty8",  64'(q8.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
